// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between the L1 I-cache
// (line refills) and the L1 D-cache (line refills and single-word stores).
module l1_mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              i_valid,
  output logic              d_valid,
  output logic              i_done,
  output logic              d_done,
  output logic [1:0]        grant
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF   = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, I_BURST, D_BURST, D_WRITE} state_e;
  typedef enum logic {LG_I, LG_D} owner_e;

  state_e                 state_q, state_d;
  owner_e                 last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-OFF-1:0]  line_q, line_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   i_valid_q, i_valid_d;
  logic                   d_valid_q, d_valid_d;
  logic                   i_done_q, i_done_d;
  logic                   d_done_q, d_done_d;
  logic [1:0]             grant_q, grant_d;
  logic                   i_elig, d_elig, pick_i, pick_d;
  logic                   unused_ok;

  assign unused_ok = ^i_addr[OFF-1:0];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    grant_d     = grant_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    // A requester whose done is still high has not yet dropped req.
    i_elig = i_req & ~i_done_q;
    d_elig = d_req & ~d_done_q;
    pick_i = i_elig & (~d_elig | (last_q == LG_D));
    pick_d = d_elig & ~pick_i;

    case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d    = I_BURST;
          last_d     = LG_I;
          cnt_d      = '0;
          line_d     = i_addr[ADDR_W-1:OFF];
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {i_addr[ADDR_W-1:OFF], {CNT_W{1'b0}}, 2'b00};
          grant_d    = 2'b01;
        end else if (pick_d) begin
          last_d   = LG_D;
          cnt_d    = '0;
          mem_en_d = 1'b1;
          grant_d  = 2'b10;
          if (d_we) begin
            state_d     = D_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d    = D_BURST;
            mem_we_d   = 1'b0;
            line_d     = d_addr[ADDR_W-1:OFF];
            mem_addr_d = {d_addr[ADDR_W-1:OFF], {CNT_W{1'b0}}, 2'b00};
          end
        end
      end
      I_BURST, D_BURST: begin
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          i_valid_d = (state_q == I_BURST);
          d_valid_d = (state_q == D_BURST);
          if (cnt_q == LAST) begin
            i_done_d = (state_q == I_BURST);
            d_done_d = (state_q == D_BURST);
            state_d  = IDLE;
            mem_en_d = 1'b0;
            grant_d  = 2'b00;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            mem_addr_d = {line_q, cnt_d, 2'b00};
          end
        end
      end
      D_WRITE: begin
        if (mem_ready) begin
          d_done_d = 1'b1;
          state_d  = IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          grant_d  = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= LG_D;
      cnt_q       <= '0;
      line_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      grant_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      grant_q     <= grant_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed and randomized bench for l1_mem_arbiter; expectations are derived
// per transaction from line base address, word index and owner.
module tb_l1_mem_arbiter;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_en, mem_we, i_valid, d_valid, i_done, d_done;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [1:0]  grant;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  l1_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rdata(rdata), .i_valid(i_valid), .d_valid(d_valid),
    .i_done(i_done), .d_done(d_done), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller raises the owner's req so it is granted at the next edge.
  // Returns the burst-cycle index (first mem_en cycle = 1) of the done cycle.
  task automatic expect_txn(input bit is_i, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit rnd,
                            input logic [31:0] mask, input logic [31:0] dbase,
                            output int cyc);
    logic [31:0] base, dv;
    logic [1:0]  gexp;
    int          n, c, guard;
    bit          got, ready, last;
    base = we ? addr : (addr & ~32'(LW * 4 - 1));
    n    = we ? 1 : LW;
    gexp = is_i ? 2'b01 : 2'b10;
    cyc  = 0;
    step();
    chk("latency_en", mem_en, 1);
    if (is_i) i_addr = $urandom;
    else begin
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    c = 1;
    for (int k = 0; k < n; k++) begin
      got = 0;
      guard = 0;
      while (!got) begin
        chk("mem_en", mem_en, 1);
        chk("mem_addr", mem_addr, base + 32'(4 * k));
        chk("mem_we", mem_we, 32'(we));
        chk("grant", grant, gexp);
        if (we) chk("mem_wdata", mem_wdata, wdata);
        if (rnd) ready = ($urandom_range(0, 2) == 0) || (guard >= 6);
        else     ready = (c < 32) ? mask[c] : 1'b1;
        dv = (dbase != 0) ? dbase + 32'(k) : $urandom;
        mem_rdata = dv;
        mem_ready = ready;
        step();
        c++;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        last = (k == n - 1);
        if (ready) begin
          got = 1;
          if (!we) chk("rdata", rdata, dv);
          chk("i_valid", i_valid, 32'(is_i && !we));
          chk("d_valid", d_valid, 32'(!is_i && !we));
          chk("i_done", i_done, 32'(last && is_i));
          chk("d_done", d_done, 32'(last && !is_i));
        end else begin
          chk("idle_valid", {i_valid, d_valid, i_done, d_done}, 0);
          guard++;
          if (guard > 40) begin
            chk("ready_timeout", 0, 1);
            return;
          end
        end
      end
    end
    chk("done_gap_en", mem_en, 0);
    chk("done_gap_grant", grant, 0);
    cyc = c;
  endtask

  initial begin
    int cyc;
    bit ri, rw;
    logic [31:0] ra, rd;
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    step(); step();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {i_valid, d_valid, i_done, d_done}, 0);
    chk("rst_grant", grant, 0);
    rst = 1'b0;

    // mem_ready with no owner must not produce return data.
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ready = 0;
    chk("stray_ready_flags", {i_valid, d_valid, i_done, d_done}, 0);
    chk("stray_ready_rdata", rdata, 0);

    // Single I refill, ready every cycle.
    i_addr = 32'h0000_1234; i_req = 1;
    expect_txn(1, 0, 32'h0000_1234, 0, 0, 32'hFFFF_FFFF, 32'hA0, cyc);
    chk("iburst_len", cyc, LW + 1);
    i_req = 0;
    step();

    // D write with three wait cycles.
    d_addr = 32'h2008; d_wdata = 32'hDEAD_BEEF; d_we = 1; d_req = 1;
    expect_txn(0, 1, 32'h2008, 32'hDEAD_BEEF, 0, 32'h10, 0, cyc);
    chk("dwrite_cycles", cyc, 5);
    d_req = 0; d_we = 0;
    step();

    // Reset the arbiter so last_grant is D, then tie.
    rst = 1; step(); rst = 0;
    i_addr = 32'h0000_4000; d_addr = 32'h0000_8010; d_we = 0;
    i_req = 1; d_req = 1;
    expect_txn(1, 0, 32'h4000, 0, 0, 32'hFFFF_FFFF, 0, cyc);
    i_req = 0;
    expect_txn(0, 0, 32'h8010, 0, 0, 32'hFFFF_FFFF, 0, cyc);
    d_req = 0;
    step();
    i_addr = 32'h0000_4100; d_addr = 32'h0000_8100;
    i_req = 1; d_req = 1;
    expect_txn(1, 0, 32'h4100, 0, 0, 32'hFFFF_FFFF, 0, cyc);
    i_req = 0;
    expect_txn(0, 0, 32'h8100, 0, 0, 32'hFFFF_FFFF, 0, cyc);
    d_req = 0;
    step();
    // Tie after an I-last sequence: D should win.
    i_addr = 32'h0000_4200; i_req = 1;
    expect_txn(1, 0, 32'h4200, 0, 0, 32'hFFFF_FFFF, 0, cyc);
    i_req = 0;
    step();
    i_addr = 32'h0000_4300; d_addr = 32'h0000_8300;
    i_req = 1; d_req = 1;
    expect_txn(0, 0, 32'h8300, 0, 0, 32'hFFFF_FFFF, 0, cyc);
    d_req = 0;
    expect_txn(1, 0, 32'h4300, 0, 0, 32'hFFFF_FFFF, 0, cyc);
    i_req = 0;
    step();

    // Stalled burst: ready on burst cycles 2,5,6,9 -> done in cycle 10.
    i_addr = 32'h0000_0C08; i_req = 1;
    expect_txn(1, 0, 32'h0C08, 0, 0, 32'h0000_0264, 0, cyc);
    chk("stall_done_cycle", cyc, 10);
    // Held request through the done cycle: no regrant.
    step();
    chk("held_no_regrant_en", mem_en, 0);
    chk("held_no_regrant_grant", grant, 0);
    i_req = 0;
    step();
    chk("held_dropped_en", mem_en, 0);

    // Reset after two of four words.
    i_addr = 32'h0000_7770; i_req = 1;
    step();
    chk("abort_en", mem_en, 1);
    mem_ready = 1;
    step(); step();
    mem_ready = 0;
    chk("abort_two_words_done", i_done, 0);
    chk("abort_mid_addr", mem_addr, 32'h7778);
    rst = 1;
    step();
    rst = 0;
    chk("abort_en_low", mem_en, 0);
    chk("abort_grant", grant, 0);
    chk("abort_flags", {i_valid, d_valid, i_done, d_done}, 0);
    chk("abort_addr", mem_addr, 0);
    i_addr = 32'h0000_7770;
    expect_txn(1, 0, 32'h7770, 0, 0, 32'hFFFF_FFFF, 0, cyc);
    i_req = 0;
    step();

    // Randomized transactions with random memory stalls.
    for (int t = 0; t < 16; t++) begin
      ri = 1'($urandom_range(0, 1));
      rw = ri ? 1'b0 : 1'($urandom_range(0, 1));
      ra = $urandom;
      if (rw) ra = ra & ~32'h3;
      rd = $urandom;
      if (ri) begin
        i_addr = ra; i_req = 1;
      end else begin
        d_addr = ra; d_wdata = rd; d_we = rw; d_req = 1;
      end
      expect_txn(ri, rw, ra, rd, 1, 0, 0, cyc);
      i_req = 0; d_req = 0;
      step();
      chk("rand_gap_en", mem_en, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Arbitrates the single external instruction/data memory port between the L1 instruction cache (line refills on miss) and the L1 data cache (line refills and single-word write-through stores). It sits between both cache controllers and the memory interface. It sequences each grant as either a 4-word burst or a 1-word write, and returns read data to the owning cache word by word. Arbitration is round-robin, so neither cache starves the other.

## Interface
Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, byte address width
- LINE_WORDS, 4, words per cache line; must be a power of two (offset = log2(LINE_WORDS)+2 bits)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  Icache refill request; level, held until i_done
- i_addr  in  ADDR_W  Icache miss address (offset bits ignored)
- d_req  in  1  Dcache request; level, held until d_done
- d_we  in  1  1 = single-word write, 0 = line refill
- d_addr  in  ADDR_W  Dcache address (word-aligned for writes)
- d_wdata  in  DATA_W  Dcache write data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  word address to memory
- mem_wdata  out  DATA_W  write data to memory
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle pulse per completed word
- rdata  out  DATA_W  returned read word (shared by both caches)
- i_valid / d_valid  out  1  rdata belongs to Icache / Dcache this cycle
- i_done / d_done  out  1  one-cycle pulse: transaction complete
- grant  out  2  current owner: 00 none, 01 I, 10 D (debug/perf)

## Operation
- States: IDLE, I_BURST, D_BURST, D_WRITE.
- In IDLE, a requester is eligible when its req=1 and its done output is 0 in the same cycle. This rule prevents regranting a request that has not yet dropped.
- When only one requester is eligible, it wins.
- When both are eligible, the winner is the one not in last_grant. last_grant resets to D, so I wins the first tie.
- On grant:
  - Latch the line base address (offset bits cleared) or the write address/data.
  - Clear the word counter cnt.
  - Update last_grant.
  - Go to I_BURST, D_BURST (d_we=0) or D_WRITE (d_we=1).
- In BURST states:
  - mem_en=1, mem_we=0, mem_addr = {base[ADDR_W-1:off], cnt, 2'b00}.
  - Each mem_ready: register rdata<=mem_rdata, pulse the owner's valid, and increment cnt.
  - On the mem_ready where cnt==LINE_WORDS-1: also pulse the owner's done and go to IDLE.
  - Words are returned in ascending order starting at word 0. There is no critical-word-first.
- D_WRITE: mem_en=1, mem_we=1, mem_addr/mem_wdata from latched values. On mem_ready: pulse d_done (no d_valid) and go to IDLE.
- mem_ready is ignored while mem_en=0.
- Input req/addr changes during an owned transaction have no effect; latched values are used.
- cnt width is log2(LINE_WORDS). Wrap-around is never reached because the FSM leaves on the last word.

## Timing
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, i_valid=d_valid=0, i_done=d_done=0, grant=00, state IDLE, cnt=0, last_grant=D.
- All outputs are registered.
- Request latency: req sampled in IDLE at edge N gives mem_en=1 from cycle N+1.
- Return: mem_ready at edge M gives rdata/valid (and done for the last word) in cycle M+1.
- mem_addr advances in cycle M+1.
- Turnaround: the FSM is IDLE in the cycle done is high. Arbitration for the next grant happens at the end of that cycle, so mem_en is low for exactly 1 cycle between back-to-back transactions.
- Requesters must drop req by the cycle after done.
- Burst of LINE_WORDS with mem_ready every cycle: mem_en high LINE_WORDS cycles.
- Reset mid-transaction: next cycle all outputs are at reset values and no done is issued. The aborted requester must re-request.
- Simultaneous i_req and d_req rising in the same cycle are resolved by last_grant. A request arriving while the other is owned waits; it is granted on the turnaround after the owner's done.

## Test plan
- Single Icache refill: i_addr=0x0000_1234, mem_ready every cycle, mem_rdata=0xA0..0xA3 -> mem_addr 0x1230,0x1234,0x1238,0x123C. Expect four i_valid pulses with rdata 0xA0..0xA3, i_done coincident with 0xA3, grant=01 during the burst.
- Dcache write: d_we=1, d_addr=0x2008, d_wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_we=1 for 4 cycles, d_done one pulse, d_valid never asserted.
- Tie from reset: i_req and d_req rise together -> I burst first. After the 1-cycle gap, D is granted. Repeat the tie immediately -> I wins again (last_grant=D).
- Stalled burst: mem_ready asserted only on cycles 2,5,6,9 -> cnt/mem_addr advance only on those cycles, and i_done arrives one cycle after cycle 9.
- Held request after done: keep i_req=1 one extra cycle after i_done -> no second grant issued on the done cycle.
- Reset mid-burst: assert rst after 2 of 4 words -> next cycle mem_en=0, grant=00, no done. A fresh i_req is granted with mem_addr starting at word 0.
